// File: rtl/lcd_sequencer.sv
// lcd_sequencer: refreshes a 2x16 character LCD from a 32-byte character
// buffer by feeding one byte at a time to a downstream lcd writer.
//
// Ports
//   iCLK        single clock, rising edge
//   iRST_N      synchronous active-low reset
//   iWR_EN      character buffer write strobe
//   iWR_ADDR    buffer address (0-15 line 1, 16-31 line 2)
//   iWR_CHAR    character code to store
//   iREQ        one-cycle refresh request
//   iLCD_DONE   transfer-complete flag from the lcd writer
//   oLCD_DATA   byte presented to the lcd writer
//   oLCD_RS     register select (0 command, 1 data)
//   oLCD_START  start level, writer begins on its rising edge
//   oBUSY       refresh in progress
//   oTIMEOUT    sticky completion-timeout flag
//
// Build option: define LCD_SEQ_AUTOREFRESH_EN to make every buffer write
// queue a refresh automatically (bursts of writes collapse into one).
//
// state   | meaning
// IDLE    | waiting for a request or a pending refresh
// LOAD    | latch table entry for current step onto data/rs
// START   | data settled, raise start on the way out
// WAIT_LO | wait for writer to drop DONE (ignores stale DONE=1)
// WAIT_HI | wait for writer to raise DONE
// DELAY   | post-transfer idle time
// NEXT    | advance step or finish
module lcd_sequencer #(
  parameter logic [17:0] DLY_CYCLES   = 18'h3FFFE,
  parameter logic [15:0] DONE_TIMEOUT = 16'hFFFF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iWR_EN,
  input  logic [4:0] iWR_ADDR,
  input  logic [7:0] iWR_CHAR,
  input  logic       iREQ,
  input  logic       iLCD_DONE,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  output logic       oBUSY,
  output logic       oTIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_LO, S_WAIT_HI, S_DELAY, S_NEXT
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'd37;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_step;
  logic [17:0] r_dly_cnt;
  logic [15:0] r_to_cnt;
  logic        r_init_done;
  logic        r_pending;
  logic [7:0]  r_data;
  logic        r_rs;
  logic        r_start;
  logic        r_timeout;
  logic [7:0]  r_buf [32];

  logic [4:0]  w_buf_idx;
  logic [7:0]  w_tbl_data;
  logic        w_tbl_rs;
  logic        w_to_hit;
  logic        w_to_event;
  logic        w_pend_set;
  logic        w_busy;

  assign w_busy   = (r_state != S_IDLE);
  assign w_to_hit = (r_to_cnt <= 16'd1);

`ifdef LCD_SEQ_AUTOREFRESH_EN
  assign w_pend_set = (iREQ && w_busy) || iWR_EN;
`else
  assign w_pend_set = iREQ && w_busy;
`endif

  // Line 2 starts at step 22 for buffer[16]; 5-bit wraparound keeps the
  // subtraction correct even though the step index itself is 6 bits.
  assign w_buf_idx = (r_step <= 6'd20) ? (r_step[4:0] - 5'd5) : (r_step[4:0] - 5'd6);

  always_comb begin
    w_tbl_data = 8'h20;
    w_tbl_rs   = 1'b0;
    case (r_step)
      6'd0:  w_tbl_data = 8'h38;
      6'd1:  w_tbl_data = 8'h0C;
      6'd2:  w_tbl_data = 8'h01;
      6'd3:  w_tbl_data = 8'h06;
      6'd4:  w_tbl_data = 8'h80;
      6'd21: w_tbl_data = 8'hC0;
      default: begin
        w_tbl_data = r_buf[w_buf_idx];
        w_tbl_rs   = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_to_event = 1'b0;
    case (r_state)
      S_IDLE:    if (iREQ || r_pending) w_next = S_LOAD;
      S_LOAD:    w_next = S_START;
      S_START:   w_next = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!iLCD_DONE) begin
          w_next = S_WAIT_HI;
        end else if (w_to_hit) begin
          w_next     = S_DELAY;
          w_to_event = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (iLCD_DONE) begin
          w_next = S_DELAY;
        end else if (w_to_hit) begin
          w_next     = S_DELAY;
          w_to_event = 1'b1;
        end
      end
      S_DELAY:   if (r_dly_cnt <= 18'd1) w_next = S_NEXT;
      S_NEXT:    w_next = (r_step >= LAST_STEP) ? S_IDLE : S_LOAD;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state     <= S_IDLE;
      r_step      <= 6'd0;
      r_dly_cnt   <= 18'd0;
      r_to_cnt    <= 16'd0;
      r_init_done <= 1'b0;
      r_pending   <= 1'b0;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_start     <= 1'b0;
      r_timeout   <= 1'b0;
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else begin
      r_state <= w_next;
      if (iWR_EN) r_buf[iWR_ADDR] <= iWR_CHAR;

      if (r_state == S_IDLE && w_next == S_LOAD) r_pending <= 1'b0;
      else if (w_pend_set)                       r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_next == S_LOAD) r_step <= r_init_done ? 6'd4 : 6'd0;
        end
        S_LOAD: begin
          r_data <= w_tbl_data;
          r_rs   <= w_tbl_rs;
        end
        // data has had a full cycle to settle before start rises
        S_START: begin
          r_start  <= 1'b1;
          r_to_cnt <= DONE_TIMEOUT;
        end
        S_WAIT_LO, S_WAIT_HI: begin
          if (r_to_cnt != 16'd0) r_to_cnt <= r_to_cnt - 16'd1;
          if (w_next == S_DELAY) begin
            r_start   <= 1'b0;
            r_dly_cnt <= DLY_CYCLES;
          end
          if (w_to_event) r_timeout <= 1'b1;
        end
        S_DELAY: begin
          if (r_dly_cnt != 18'd0) r_dly_cnt <= r_dly_cnt - 18'd1;
        end
        S_NEXT: begin
          if (r_step == 6'd3) r_init_done <= 1'b1;
          if (r_step < LAST_STEP) r_step <= r_step + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign oLCD_DATA  = r_data;
  assign oLCD_RS    = r_rs;
  assign oLCD_START = r_start;
  assign oBUSY      = w_busy;
  assign oTIMEOUT   = r_timeout;

endmodule

// File: tb/tb_lcd_sequencer.sv
module tb_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       req;
  logic       lcd_done;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_start;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] m_buf [32];
  logic [8:0] cap [$];
  logic       hold_done = 1'b0;
  logic       mdl_prev  = 1'b0;
  int         done_cnt  = 0;
  logic       mon_prev  = 1'b0;

  always #5 clk = ~clk;

  lcd_sequencer #(.DLY_CYCLES(18'd4), .DONE_TIMEOUT(16'd32)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iWR_EN(wr_en), .iWR_ADDR(wr_addr),
    .iWR_CHAR(wr_char), .iREQ(req), .iLCD_DONE(lcd_done),
    .oLCD_DATA(lcd_data), .oLCD_RS(lcd_rs), .oLCD_START(lcd_start),
    .oBUSY(busy), .oTIMEOUT(timeout)
  );

  // lcd writer model: DONE drops one cycle after START rises, returns 18 later
  initial lcd_done = 1'b1;
  always @(posedge clk) begin
    mdl_prev <= lcd_start;
    if (hold_done) begin
      lcd_done <= 1'b1;
      done_cnt <= 0;
    end else if (lcd_start && !mdl_prev) begin
      lcd_done <= 1'b0;
      done_cnt <= 18;
    end else if (done_cnt != 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) lcd_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    mon_prev <= lcd_start;
    if (lcd_start && !mon_prev) cap.push_back({lcd_rs, lcd_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model_entry(input int step);
    if (step == 0) return 9'h038;
    if (step == 1) return 9'h00C;
    if (step == 2) return 9'h001;
    if (step == 3) return 9'h006;
    if (step == 4) return 9'h080;
    if (step == 21) return 9'h0C0;
    if (step >= 5 && step <= 20) return {1'b1, m_buf[step - 5]};
    return {1'b1, m_buf[step - 22 + 16]};
  endfunction

  task automatic pulse_req();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_seq(input string tag, input int first_step, input int nexp);
    check({tag, "_count"}, cap.size(), nexp);
    for (int i = 0; i < nexp && i < cap.size(); i++)
      check($sformatf("%s_step%0d", tag, first_step + i), {23'd0, cap[i]},
            {23'd0, model_entry(first_step + i)});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_char = 8'd0; req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data",    {24'd0, lcd_data}, 32'h00);
    check("rst_rs",      {31'd0, lcd_rs}, 32'd0);
    check("rst_start",   {31'd0, lcd_start}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;

    // full refresh including init
    cap.delete();
    pulse_req();
    check("r1_busy_hi", {31'd0, busy}, 32'd1);
    wait_idle("r1_idle");
    check_seq("r1", 0, 38);

    // init already done: starts at cursor command
    cap.delete();
    pulse_req();
    wait_idle("r2_idle");
    check_seq("r2", 4, 34);

    // buffer write lands in next refresh
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd17; wr_char = 8'h41;
    @(negedge clk);
    wr_en = 1'b0;
    m_buf[17] = 8'h41;
    cap.delete();
    pulse_req();
    wait_idle("r3_idle");
    check("r3_xfer20", {23'd0, cap[19]}, 32'h141);
    check_seq("r3", 4, 34);

    // three requests while busy collapse into one extra refresh
    cap.delete();
    pulse_req();
    repeat (50) @(negedge clk);
    pulse_req();
    repeat (20) @(negedge clk);
    pulse_req();
    repeat (20) @(negedge clk);
    pulse_req();
    repeat (2500) @(negedge clk);
    check("multi_busy", {31'd0, busy}, 32'd0);
    check("multi_count", cap.size(), 68);
    check("multi_second_first", {23'd0, cap[34]}, 32'h080);

    // DONE stuck high: every step times out but the refresh completes
    hold_done = 1'b1;
    cap.delete();
    pulse_req();
    wait_idle("to_idle");
    check("to_flag", {31'd0, timeout}, 32'd1);
    check("to_count", cap.size(), 34);
    check("to_first", {23'd0, cap[0]}, 32'h080);
    hold_done = 1'b0;
    repeat (5) @(negedge clk);

    // reset mid-refresh, during step 10
    cap.delete();
    pulse_req();
    begin
      int n = 0;
      while (cap.size() < 7 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("mid_reached", {31'd0, cap.size() >= 7}, 32'd1);
    end
    check("mid_start_hi", {31'd0, lcd_start}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_start", {31'd0, lcd_start}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_timeout", {31'd0, timeout}, 32'd0);
    check("mid_data", {24'd0, lcd_data}, 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    repeat (30) @(negedge clk);
    cap.delete();
    pulse_req();
    wait_idle("r4_idle");
    check_seq("r4", 0, 38);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter DLY_CYCLES, default 18'h3FFFE: idle cycles inserted after each completed LCD transfer.
REQ-002 Parameter DONE_TIMEOUT, default 16'hFFFF: maximum cycles to wait for transfer completion.
REQ-003 iCLK  in  1  single clock; every register is updated on its rising edge.
REQ-004 iRST_N  in  1  synchronous, active-low reset.
REQ-005 iWR_EN  in  1  character-buffer write strobe.
REQ-006 iWR_ADDR  in  5  buffer address; 0-15 is line 1, 16-31 is line 2.
REQ-007 iWR_CHAR  in  8  ASCII code to write.
REQ-008 iREQ  in  1  one-cycle pulse requesting a full screen refresh.
REQ-009 iLCD_DONE  in  1  transfer-complete flag from the downstream lcd writer.
REQ-010 oLCD_DATA  out  8  byte presented to the lcd writer.
REQ-011 oLCD_RS  out  1  register select; 0 = command, 1 = data.
REQ-012 oLCD_START  out  1  start level; the lcd writer begins a transfer on its rising edge.
REQ-013 oBUSY  out  1  high while a refresh is in progress.
REQ-014 oTIMEOUT  out  1  sticky flag indicating a completion timeout occurred.

Function
REQ-015 The block SHALL contain a 32x8 character buffer; a write with iWR_EN=1 SHALL store iWR_CHAR at iWR_ADDR on the same edge, in any state.
REQ-016 The step table, indexed 0-37, SHALL be:
- steps 0-3: commands 0x38, 0x0C, 0x01, 0x06 (RS=0);
- step 4: command 0x80;
- steps 5-20: buffer[0..15] (RS=1);
- step 21: command 0xC0;
- steps 22-37: buffer[16..31] (RS=1).
REQ-017 The FSM states SHALL be IDLE, LOAD, START, WAIT_LO, WAIT_HI, DELAY, NEXT.
REQ-018 IDLE to LOAD SHALL occur when iREQ=1 or the pending flag is set; the start step SHALL be 0 if init_done=0, otherwise 4; the pending flag SHALL be cleared on this transition.
REQ-019 LOAD SHALL register the table entry for the current step into oLCD_DATA/oLCD_RS, then go to START.
REQ-020 START SHALL drive oLCD_START=1, then go to WAIT_LO.
- oLCD_DATA/oLCD_RS SHALL remain stable from LOAD until DELAY is entered.
REQ-021 WAIT_LO SHALL wait for iLCD_DONE=0, then go to WAIT_HI.
REQ-022 WAIT_HI SHALL wait for iLCD_DONE=1, then drive oLCD_START=0 and go to DELAY.
- A stale DONE=1 from the previous transfer SHALL never complete a step.
REQ-023 DELAY SHALL count exactly DLY_CYCLES cycles, then go to NEXT.
REQ-024 NEXT SHALL act as follows:
- after step 3: set init_done;
- if the step is 37: go to IDLE;
- otherwise: increment the step and go to LOAD.
REQ-025 If a refresh lasts DONE_TIMEOUT cycles in WAIT_LO+WAIT_HI combined:
- oTIMEOUT SHALL be set;
- oLCD_START SHALL be driven to 0;
- the FSM SHALL proceed to DELAY as though the transfer completed.
REQ-026 oBUSY SHALL be 1 in every state except IDLE.
REQ-027 An iREQ arriving while busy SHALL set the pending flag; multiple such requests SHALL collapse into one pending refresh.
REQ-028 Buffer characters SHALL be sampled in LOAD, so a write to an entry not yet sent appears in the current refresh.
REQ-029 Step and delay counters SHALL never wrap; the step index SHALL saturate at 37.

Reset
REQ-030 With iRST_N=0 at a clock edge, the block SHALL reset as follows:
- state = IDLE, step = 0, delay count = 0;
- init_done = 0, pending = 0;
- oLCD_START = 0, oLCD_DATA = 0x00, oLCD_RS = 0;
- oBUSY = 0, oTIMEOUT = 0;
- all buffer bytes = 0x20.
REQ-031 Reset mid-refresh SHALL abort the refresh immediately, drop oLCD_START on the same edge, and re-run init on the next request.

Configuration
REQ-032 With LCD_SEQ_AUTOREFRESH_EN defined:
- any buffer write SHALL set the pending flag;
- the buffer is thereby redrawn automatically after edits, one refresh per burst of writes.
REQ-033 Without LCD_SEQ_AUTOREFRESH_EN, only iREQ SHALL set the pending flag or start a refresh.

Verification
REQ-034 Bench SHALL cover these directed scenarios (DLY_CYCLES=4; bench model of lcd writer clears DONE 1 cycle after START rises and sets it 18 cycles later):
- Reset, then iREQ -> 38 START pulses; bytes 38,0C,01,06,80, sixteen 20, C0, sixteen 20; RS per table; oBUSY falls after step 37.
- Second iREQ -> exactly 34 transfers, the first being 0x80.
- Write 'A' (0x41) to addr 17, then iREQ -> transfer 20 (1-based) is 0x41 with RS=1.
- iREQ three times while busy -> exactly one additional refresh follows.
- Model holds DONE=1 with DONE_TIMEOUT=32 -> oTIMEOUT=1, sequence completes, oBUSY returns to 0.
- iRST_N low during step 10 -> oLCD_START=0 next edge; next iREQ restarts at 0x38.
